// File: rtl/rib_arbiter_pkg.sv
// Shared master index constants and small helpers for the rib six-master arbiter.
package rib_arbiter_pkg;

    localparam int MASTER_NUM = 6;

    localparam logic [2:0] M_C0_EX = 3'd0;
    localparam logic [2:0] M_C0_PC = 3'd1;
    localparam logic [2:0] M_JTAG0 = 3'd2;
    localparam logic [2:0] M_C1_EX = 3'd3;
    localparam logic [2:0] M_C1_PC = 3'd4;
    localparam logic [2:0] M_JTAG1 = 3'd5;

    typedef logic [MASTER_NUM-1:0] mvec_t;

    // Masters m0-m2 belong to core0, m3-m5 to core1.
    function automatic logic owner_core(input logic [2:0] idx);
        return (idx >= M_C1_EX);
    endfunction

    function automatic logic is_jtag(input logic [2:0] idx);
        return (idx == M_JTAG0) || (idx == M_JTAG1);
    endfunction

    // Inter-core tie: the core that did not own the previous grant wins.
    function automatic logic [2:0] tie_pick(input logic last_core,
                                             input logic [2:0] c0_idx,
                                             input logic [2:0] c1_idx);
        return last_core ? c0_idx : c1_idx;
    endfunction

endpackage

// File: rtl/rib_arb_waitcnt.sv
// Per-core saturating wait counter; starve is high while the count sits at MAX_WAIT.
module rib_arb_waitcnt #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic starve
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Count held cycles, clearing on grant or when the core stops requesting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (inc && (cnt_r != MAX_CNT)) begin
            cnt_r <= cnt_r + ONE;
        end
    end

    assign starve = (cnt_r == MAX_CNT);

endmodule

// File: rtl/rib_arbiter.sv
// Six-master rib arbiter: jtag > ex > pc classes, starvation promotion,
// round-robin tie break between cores and a sticky jtag lock.
module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  req_i,
    output logic [5:0]  grant_o,
    output logic [2:0]  grant_idx_o,
    output logic        grant_valid_o,
    output logic [1:0]  hold_flag_o,
    output logic [1:0]  starve_o
);

    logic       last_core_r;
    logic       lock_vld_r;
    logic [2:0] lock_id_r;
    logic [1:0] starve_s;
    logic       lock_hit_s;
    logic       nj0_s;
    logic       nj1_s;
    logic       prom0_s;
    logic       prom1_s;
    logic       sel_vld_s;
    logic [2:0] sel_idx_s;
    logic [1:0] core_gnt_s;

    assign nj0_s      = req_i[M_C0_EX] | req_i[M_C0_PC];
    assign nj1_s      = req_i[M_C1_EX] | req_i[M_C1_PC];
    assign prom0_s    = starve_s[0] & nj0_s;
    assign prom1_s    = starve_s[1] & nj1_s;
    assign lock_hit_s = lock_vld_r & req_i[lock_id_r];

    // Pick the winning master index for this cycle.
    always_comb begin
        sel_vld_s = 1'b1;
        sel_idx_s = 3'd0;
        if (!rst) begin
            sel_vld_s = 1'b0;
        end else if (lock_hit_s) begin
            sel_idx_s = lock_id_r;
        end else if (req_i[M_JTAG0] && req_i[M_JTAG1]) begin
            sel_idx_s = tie_pick(last_core_r, M_JTAG0, M_JTAG1);
        end else if (req_i[M_JTAG0]) begin
            sel_idx_s = M_JTAG0;
        end else if (req_i[M_JTAG1]) begin
            sel_idx_s = M_JTAG1;
        end else if (prom0_s && !prom1_s) begin
            sel_idx_s = req_i[M_C0_EX] ? M_C0_EX : M_C0_PC;
        end else if (prom1_s && !prom0_s) begin
            sel_idx_s = req_i[M_C1_EX] ? M_C1_EX : M_C1_PC;
        end else if (req_i[M_C0_EX] && req_i[M_C1_EX]) begin
            sel_idx_s = tie_pick(last_core_r, M_C0_EX, M_C1_EX);
        end else if (req_i[M_C0_EX]) begin
            sel_idx_s = M_C0_EX;
        end else if (req_i[M_C1_EX]) begin
            sel_idx_s = M_C1_EX;
        end else if (req_i[M_C0_PC] && req_i[M_C1_PC]) begin
            sel_idx_s = tie_pick(last_core_r, M_C0_PC, M_C1_PC);
        end else if (req_i[M_C0_PC]) begin
            sel_idx_s = M_C0_PC;
        end else if (req_i[M_C1_PC]) begin
            sel_idx_s = M_C1_PC;
        end else begin
            sel_vld_s = 1'b0;
        end
    end

    assign grant_o       = sel_vld_s ? (6'b000001 << sel_idx_s) : 6'b000000;
    assign grant_idx_o   = sel_vld_s ? sel_idx_s : 3'd0;
    assign grant_valid_o = sel_vld_s;

    // A granted jtag master does not release the core pipeline from hold.
    assign hold_flag_o[0] = rst & nj0_s & ~(grant_o[M_C0_EX] | grant_o[M_C0_PC]);
    assign hold_flag_o[1] = rst & nj1_s & ~(grant_o[M_C1_EX] | grant_o[M_C1_PC]);
    assign starve_o       = starve_s & {2{rst}};

    assign core_gnt_s[0] = sel_vld_s & ~owner_core(sel_idx_s);
    assign core_gnt_s[1] = sel_vld_s &  owner_core(sel_idx_s);

    // Round-robin owner and jtag lock state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_core_r <= 1'b0;
            lock_vld_r  <= 1'b0;
            lock_id_r   <= 3'd0;
        end else begin
            if (sel_vld_s) begin
                last_core_r <= owner_core(sel_idx_s);
            end
            if (lock_vld_r) begin
                lock_vld_r <= req_i[lock_id_r];
            end else if (sel_vld_s && is_jtag(sel_idx_s)) begin
                lock_vld_r <= 1'b1;
                lock_id_r  <= sel_idx_s;
            end
        end
    end

    rib_arb_waitcnt #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_wait0 (
        .clk    (clk),
        .rst    (rst),
        .clr    (core_gnt_s[0] | ~nj0_s),
        .inc    (nj0_s),
        .starve (starve_s[0])
    );

    rib_arb_waitcnt #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) u_wait1 (
        .clk    (clk),
        .rst    (rst),
        .clr    (core_gnt_s[1] | ~nj1_s),
        .inc    (nj1_s),
        .starve (starve_s[1])
    );

endmodule

// File: tb/tb_rib_arbiter.sv
// Scoreboard bench for rib_arbiter: directed vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_rib_arbiter;

    logic       clk;
    logic       rst;
    logic [5:0] req_i;
    logic [5:0] grant_o;
    logic [2:0] grant_idx_o;
    logic       grant_valid_o;
    logic [1:0] hold_flag_o;
    logic [1:0] starve_o;

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];
    string       name_q[$];

    rib_arbiter #(.MAX_WAIT(4), .CNT_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req_i),
        .grant_o       (grant_o),
        .grant_idx_o   (grant_idx_o),
        .grant_valid_o (grant_valid_o),
        .hold_flag_o   (hold_flag_o),
        .starve_o      (starve_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one vector just after the rising edge and queue its expected outputs.
    task automatic vec(input string name, input logic r, input logic [5:0] req,
                       input logic [5:0] g, input logic [1:0] h, input logic [1:0] s);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (g[i]) idx = 3'(i);
        end
        @(posedge clk);
        #1;
        rst   = r;
        req_i = req;
        exp_q.push_back({g, idx, |g, h, s});
        name_q.push_back(name);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [13:0] e;
            logic [13:0] a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {grant_o, grant_idx_o, grant_valid_o, hold_flag_o, starve_o};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got grant=%b idx=%0d vld=%b hold=%b starve=%b, want grant=%b idx=%0d vld=%b hold=%b starve=%b",
                         n, a[13:8], a[7:5], a[4], a[3:2], a[1:0],
                         e[13:8], e[7:5], e[4], e[3:2], e[1:0]);
            end
        end
    end

    initial begin
        rst   = 1'b0;
        req_i = 6'b000000;

        // Reset and alternating pc grants
        vec("reset",      1'b0, 6'b111111, 6'b000000, 2'b00, 2'b00);
        vec("rr_pc_1",    1'b1, 6'b010010, 6'b010000, 2'b01, 2'b00);
        vec("rr_pc_2",    1'b1, 6'b010010, 6'b000010, 2'b10, 2'b00);
        vec("rr_pc_3",    1'b1, 6'b010010, 6'b010000, 2'b01, 2'b00);
        vec("rr_pc_4",    1'b1, 6'b010010, 6'b000010, 2'b10, 2'b00);
        // Class priority
        vec("class_ex",   1'b1, 6'b011010, 6'b001000, 2'b01, 2'b00);
        // Starvation of core0 behind locked m5
        vec("starve_j0",  1'b1, 6'b111011, 6'b100000, 2'b11, 2'b00);
        vec("starve_j1",  1'b1, 6'b111011, 6'b100000, 2'b11, 2'b00);
        vec("starve_j2",  1'b1, 6'b111011, 6'b100000, 2'b11, 2'b00);
        vec("starve_set", 1'b1, 6'b111011, 6'b100000, 2'b11, 2'b01);
        vec("promote_m0", 1'b1, 6'b011011, 6'b000001, 2'b10, 2'b01);
        vec("starve_clr", 1'b1, 6'b011011, 6'b001000, 2'b01, 2'b00);
        // Jtag lock on m2
        vec("lock_m2",    1'b1, 6'b000100, 6'b000100, 2'b00, 2'b00);
        for (int i = 0; i < 10; i++) begin
            vec("lock_hold", 1'b1, 6'b100101, 6'b000100, 2'b01, 2'b00);
        end
        vec("lock_drop",  1'b1, 6'b100001, 6'b100000, 2'b01, 2'b00);
        // Mid-lock reset on m5
        vec("relock_m5",  1'b1, 6'b100001, 6'b100000, 2'b01, 2'b00);
        vec("lock_m5",    1'b1, 6'b100001, 6'b100000, 2'b01, 2'b00);
        vec("mid_rst",    1'b0, 6'b100001, 6'b000000, 2'b00, 2'b00);
        vec("post_rst",   1'b1, 6'b100100, 6'b100000, 2'b00, 2'b00);
        vec("no_stale",   1'b1, 6'b000100, 6'b000100, 2'b00, 2'b00);
        // Core1 starvation behind m2, then idle
        vec("c1_wait0",   1'b1, 6'b001100, 6'b000100, 2'b10, 2'b00);
        vec("c1_wait1",   1'b1, 6'b001100, 6'b000100, 2'b10, 2'b00);
        vec("c1_wait2",   1'b1, 6'b001100, 6'b000100, 2'b10, 2'b00);
        vec("c1_wait3",   1'b1, 6'b001100, 6'b000100, 2'b10, 2'b00);
        vec("c1_starve",  1'b1, 6'b001100, 6'b000100, 2'b10, 2'b10);
        vec("idle_0",     1'b1, 6'b000000, 6'b000000, 2'b00, 2'b10);
        vec("idle_1",     1'b1, 6'b000000, 6'b000000, 2'b00, 2'b00);
        vec("idle_2",     1'b1, 6'b000000, 6'b000000, 2'b00, 2'b00);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
